multi_pwm_bank: RTL and testbench

MULTI_PWM_BANK -- requirements
Module: multi_pwm_bank

---
 rtl/multi_pwm_bank.sv | 173 +++++++++++++++++
 tb/tb_multi_pwm_bank.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/multi_pwm_bank.sv
// multi_pwm_bank -- bank of NUM_CH PWM channels sharing one prescaler and
// one period counter.
//
// Build option: define MULTI_PWM_BANK_SHADOW_EN to double-buffer the duty
// registers. With it, a write lands in a shadow register and becomes active
// at the next period wrap, or on every cycle while enable is low. Without it,
// a write changes the active duty immediately.
//
// Ports
//   S_AXI_ACLK     sole clock, rising edge
//   S_AXI_ARESETN  synchronous active-low reset
//   enable         run control; low holds prescaler and counter at 0
//   clk_div        prescaler; one tick every clk_div+1 cycles
//   period         period in ticks (0 behaves as 1)
//   wr_en/wr_ch/wr_duty  single-cycle duty write; out-of-range wr_ch is ignored
//   force_en/force_val   per-channel output override
//   pwm_out        registered PWM outputs
//   period_start   one-cycle pulse after each period wrap
//   cycle_count    number of completed periods (wraps at 2^32)

// One channel: the duty register(s) and the registered output.
module multi_pwm_lane #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [CNT_W-1:0] cnt,
`ifdef MULTI_PWM_BANK_SHADOW_EN
    input  logic             load,
`endif
    input  logic             wr_hit,
    input  logic [CNT_W-1:0] wr_duty,
    input  logic             force_en,
    input  logic             force_val,
    output logic             pwm_out
);
    logic [CNT_W-1:0] duty_active_q, duty_active_d;
    logic             pwm_q, pwm_d;

`ifdef MULTI_PWM_BANK_SHADOW_EN
    logic [CNT_W-1:0] duty_shadow_q, duty_shadow_d;

    always_comb begin
        duty_shadow_d = wr_hit ? wr_duty : duty_shadow_q;
        duty_active_d = duty_active_q;
        // A write landing on the load cycle goes straight through so it is
        // not lost behind the stale shadow value.
        if (load) duty_active_d = wr_hit ? wr_duty : duty_shadow_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) duty_shadow_q <= '0;
        else        duty_shadow_q <= duty_shadow_d;
    end
`else
    always_comb begin
        duty_active_d = duty_active_q;
        if (wr_hit) duty_active_d = wr_duty;
    end
`endif

    // The comparison uses cnt before this edge's update, so the output
    // lags the counter by one cycle. duty 0 never matches (constant low);
    // duty >= period always matches (constant high).
    always_comb begin
        pwm_d = force_en ? force_val : (enable && (cnt < duty_active_q));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            duty_active_q <= '0;
            pwm_q         <= 1'b0;
        end else begin
            duty_active_q <= duty_active_d;
            pwm_q         <= pwm_d;
        end
    end

    assign pwm_out = pwm_q;
endmodule

module multi_pwm_bank #(
    parameter int NUM_CH = 16,
    parameter int CNT_W  = 32,
    parameter int CH_W   = 4
) (
    input  logic              S_AXI_ACLK,
    input  logic              S_AXI_ARESETN,
    input  logic              enable,
    input  logic [CNT_W-1:0]  clk_div,
    input  logic [CNT_W-1:0]  period,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [CNT_W-1:0]  wr_duty,
    input  logic [NUM_CH-1:0] force_en,
    input  logic [NUM_CH-1:0] force_val,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              period_start,
    output logic [31:0]       cycle_count
);
    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] pre_q, pre_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      cycle_count_q, cycle_count_d;
    logic             period_start_q, period_start_d;
    logic [CNT_W-1:0] eff_period;
    logic             tick, wrap, wr_ok;

    always_comb begin
        eff_period = (period == '0) ? ONE : period;
        tick       = enable && (pre_q == clk_div);
        // >= rather than == so a period shrunk below cnt wraps on the next
        // tick instead of running on to 2^CNT_W.
        wrap       = tick && (cnt_q >= (eff_period - ONE));
        wr_ok      = wr_en && (32'(wr_ch) < 32'(NUM_CH));

        pre_d = pre_q;
        cnt_d = cnt_q;
        if (!enable) begin
            pre_d = '0;
            cnt_d = '0;
        end else begin
            pre_d = tick ? '0 : (pre_q + ONE);
            if (tick) cnt_d = wrap ? '0 : (cnt_q + ONE);
        end

        cycle_count_d  = cycle_count_q + {31'd0, wrap};
        period_start_d = wrap;
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            pre_q          <= '0;
            cnt_q          <= '0;
            cycle_count_q  <= '0;
            period_start_q <= 1'b0;
        end else begin
            pre_q          <= pre_d;
            cnt_q          <= cnt_d;
            cycle_count_q  <= cycle_count_d;
            period_start_q <= period_start_d;
        end
    end

`ifdef MULTI_PWM_BANK_SHADOW_EN
    // Shadows move to active at each wrap, and continuously while stopped so
    // that a restart begins with the latest values.
    logic load;
    assign load = wrap || !enable;
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
        multi_pwm_lane #(.CNT_W(CNT_W)) u_lane (
            .clk       (S_AXI_ACLK),
            .rst_n     (S_AXI_ARESETN),
            .enable    (enable),
            .cnt       (cnt_q),
`ifdef MULTI_PWM_BANK_SHADOW_EN
            .load      (load),
`endif
            .wr_hit    (wr_ok && (32'(wr_ch) == 32'(g))),
            .wr_duty   (wr_duty),
            .force_en  (force_en[g]),
            .force_val (force_val[g]),
            .pwm_out   (pwm_out[g])
        );
    end

    assign period_start = period_start_q;
    assign cycle_count  = cycle_count_q;
endmodule

// File: tb/tb_multi_pwm_bank.sv
module tb_multi_pwm_bank;
    localparam int NCH = 16;
    localparam int CW  = 32;
    localparam int CHW = 5;

    logic            clk = 1'b0;
    logic            rstn;
    logic            enable;
    logic [CW-1:0]   clk_div, period, wr_duty;
    logic            wr_en;
    logic [CHW-1:0]  wr_ch;
    logic [NCH-1:0]  force_en, force_val;
    logic [NCH-1:0]  pwm_out;
    logic            period_start;
    logic [31:0]     cycle_count;

    int checks = 0;
    int errors = 0;

    // Reference state, advanced once per rising edge from the pin values.
    bit [31:0]    m_pre, m_cnt, m_cc;
    bit [31:0]    m_duty[NCH];
    bit [31:0]    m_shadow[NCH];
    bit [NCH-1:0] m_pwm;
    bit           m_ps;

    always #5 clk = ~clk;

    multi_pwm_bank #(.NUM_CH(NCH), .CNT_W(CW), .CH_W(CHW)) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rstn), .enable(enable),
        .clk_div(clk_div), .period(period), .wr_en(wr_en), .wr_ch(wr_ch),
        .wr_duty(wr_duty), .force_en(force_en), .force_val(force_val),
        .pwm_out(pwm_out), .period_start(period_start), .cycle_count(cycle_count)
    );

    task automatic model_edge();
        bit [31:0] eff;
        bit tick, wrap, load, hit;
        if (!rstn) begin
            m_pre = 0; m_cnt = 0; m_cc = 0; m_pwm = '0; m_ps = 0;
            for (int i = 0; i < NCH; i++) begin m_duty[i] = 0; m_shadow[i] = 0; end
        end else begin
            eff  = (period == 0) ? 32'd1 : period;
            tick = enable && (m_pre == clk_div);
            wrap = tick && (m_cnt + 1 >= eff);
            for (int i = 0; i < NCH; i++)
                m_pwm[i] = force_en[i] ? force_val[i] : (enable && (m_cnt < m_duty[i]));
            m_ps = wrap;
            if (wrap) m_cc = m_cc + 1;
            load = wrap || !enable;
            if (!enable) begin
                m_pre = 0; m_cnt = 0;
            end else if (tick) begin
                m_pre = 0;
                m_cnt = wrap ? 0 : m_cnt + 1;
            end else begin
                m_pre = m_pre + 1;
            end
            for (int i = 0; i < NCH; i++) begin
                hit = wr_en && (int'(wr_ch) == i);
`ifdef MULTI_PWM_BANK_SHADOW_EN
                if (load) m_duty[i] = hit ? wr_duty : m_shadow[i];
                if (hit) m_shadow[i] = wr_duty;
`else
                if (hit) m_duty[i] = wr_duty;
`endif
            end
        end
    endtask

    task automatic check_outputs();
        checks++;
        assert (pwm_out === m_pwm) else begin
            errors++;
            $error("FAIL pwm_out got=%h exp=%h t=%0t", pwm_out, m_pwm, $time);
        end
        checks++;
        assert (period_start === m_ps) else begin
            errors++;
            $error("FAIL period_start got=%b exp=%b t=%0t", period_start, m_ps, $time);
        end
        checks++;
        assert (cycle_count === m_cc) else begin
            errors++;
            $error("FAIL cycle_count got=%0d exp=%0d t=%0t", cycle_count, m_cc, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic write(input int ch, input int duty);
        wr_en = 1; wr_ch = CHW'(ch); wr_duty = CW'(duty);
        step();
        wr_en = 0;
    endtask

    task automatic do_reset();
        rstn = 0; step(); rstn = 1;
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got == exp) else begin
            errors++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    initial begin
        int ones[4];
        int nps, n;
        rstn = 0; enable = 0; clk_div = 0; period = 4; wr_en = 0; wr_ch = 0;
        wr_duty = 0; force_en = '0; force_val = '0;
        @(negedge clk);

        // Reset state
        step(); step();
        chk("reset_pwm", int'(pwm_out), 0);
        chk("reset_cc", int'(cycle_count), 0);
        rstn = 1;

        // Basic four-channel pattern, period 4, no prescale
        write(0, 1); write(1, 2); write(2, 0); write(3, 4);
        enable = 1;
        repeat (8) step();
        ones = '{0, 0, 0, 0}; nps = 0;
        repeat (16) begin
            step();
            for (int c = 0; c < 4; c++) ones[c] += int'(pwm_out[c]);
            nps += int'(period_start);
        end
        chk("ch0_high", ones[0], 4);
        chk("ch1_high", ones[1], 8);
        chk("ch2_high", ones[2], 0);
        chk("ch3_high", ones[3], 16);
        chk("ps_count", nps, 4);

        // Prescaled: clk_div=2, period=5, duty=2
        enable = 0; do_reset();
        clk_div = 2; period = 5; write(0, 2);
        enable = 1;
        n = 0;
        for (int k = 1; k <= 45; k++) begin
            step();
            if (k > 15) n += int'(pwm_out[0]);
        end
        chk("presc_cc", int'(cycle_count), 3);
        chk("presc_high", n, 12);

        // Mid-period duty rewrite, period 8
        enable = 0; clk_div = 0; period = 8; write(0, 2);
        enable = 1;
        while (m_cnt != 1) step();
        write(0, 6);
        repeat (20) step();

        // Period shrink below current count forces a wrap on the next tick
        period = 10;
        n = 0;
        while (m_cnt != 7 && n < 50) begin step(); n++; end
        chk("reach_cnt7", int'(m_cnt), 7);
        period = 3;
        step();
        chk("shrink_wrap", int'(period_start), 1);
        repeat (3) step();
        chk("shrink_next", int'(period_start), 1);

        // Force with enable low; write to an out-of-range channel
        enable = 0; force_en[5] = 1; force_val[5] = 1;
        step();
        chk("force5", int'(pwm_out[5]), 1);
        write(NCH, 9);
        write(NCH + 1, 3);
        force_en = '0;
        repeat (3) step();

        // Reset mid-period at cnt=3, then time to the first period_start
        clk_div = 1; period = 4; enable = 1;
        n = 0;
        while (m_cnt != 3 && n < 50) begin step(); n++; end
        do_reset();
        chk("rst_pwm", int'(pwm_out), 0);
        chk("rst_cc", int'(cycle_count), 0);
        chk("rst_ps", int'(period_start), 0);
        n = 0;
        while (!period_start && n < 100) begin step(); n++; end
        chk("first_ps_delay", n, 8);

        // Randomized traffic against the reference model
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 299) == 0) rstn = 0;
            else rstn = 1;
            if ($urandom_range(0, 49) == 0) enable = ~enable;
            if ($urandom_range(0, 59) == 0) clk_div = CW'($urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0) period = CW'($urandom_range(0, 9));
            if ($urandom_range(0, 19) == 0) begin
                force_en  = NCH'($urandom) & NCH'($urandom);
                force_val = NCH'($urandom);
            end
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_ch   = CHW'($urandom_range(0, NCH + 1));
            wr_duty = CW'($urandom_range(0, 10));
            step();
        end
        wr_en = 0; rstn = 1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
